// File: rtl/train_sequencer.sv
// Route-step sequencer: walks Selector 0..15 on Y, dwells on timed steps 2..5, counts laps.
// Define TRAIN_SEQ_WATCHDOG_EN to build the WAIT watchdog and its FAULT state.
module train_sequencer #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned WDOG_CYCLES  = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Y,
  output logic [3:0] Selector,
  output logic       Enable,
  output logic       TIMER,
  output logic [7:0] Laps,
  output logic       Fault
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, FAULT} state_t;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  state_t      state;
  logic [31:0] dwellCnt;
  logic        stopPend;
  logic        timedStep;

  assign timedStep = (Selector >= 4'd2) && (Selector <= 4'd5);

`ifdef TRAIN_SEQ_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  logic [31:0] wdogCnt;
`else
  logic unusedWdogParam;
  assign unusedWdogParam = (WDOG_CYCLES == 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      Selector <= '0;
      Laps     <= '0;
      dwellCnt <= '0;
      stopPend <= 1'b0;
`ifdef TRAIN_SEQ_WATCHDOG_EN
      wdogCnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Selector <= '0;
          stopPend <= 1'b0;
          if (Start && !Stop) state <= SETTLE;
        end
        SETTLE: begin
          dwellCnt <= '0;
`ifdef TRAIN_SEQ_WATCHDOG_EN
          wdogCnt  <= '0;
`endif
          if (Stop) stopPend <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (Y) begin
            // the lap is credited even when this advance ends the run
            if (Selector == 4'hF && Laps != 8'hFF) Laps <= Laps + 8'd1;
            if (stopPend || Stop) begin
              state    <= IDLE;
              Selector <= '0;
              stopPend <= 1'b0;
            end else begin
              state    <= SETTLE;
              Selector <= Selector + 4'd1;
            end
          end else begin
            if (Stop) stopPend <= 1'b1;
            if (timedStep && dwellCnt != DWELL_LAST) dwellCnt <= dwellCnt + 32'd1;
`ifdef TRAIN_SEQ_WATCHDOG_EN
            if (wdogCnt == WDOG_LAST) state <= FAULT;
            else wdogCnt <= wdogCnt + 32'd1;
`endif
          end
        end
        FAULT: begin
          if (Stop) begin
            state    <= IDLE;
            Selector <= '0;
            stopPend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Enable = (state == SETTLE) || (state == WAIT);
  assign TIMER  = (state == WAIT) && timedStep && (dwellCnt == DWELL_LAST);
`ifdef TRAIN_SEQ_WATCHDOG_EN
  assign Fault  = (state == FAULT);
`else
  assign Fault  = 1'b0;
`endif

endmodule
